bankgroup_req_ctrl: RTL and testbench

//  Upstream sequencer for one bankgroup: accepts valid/ready requests (read/write, random or FIFO mode),

---
 rtl/bankgroup_req_ctrl_pkg.sv | 10 +
 rtl/bankgroup_req_ctrl_if.sv | 17 +
 rtl/bankgroup_req_ctrl_rsp_queue.sv | 34 +++
 rtl/bankgroup_req_ctrl.sv | 104 ++++++++++
 tb/tb_bankgroup_req_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bankgroup_req_ctrl_pkg.sv
// bankgroup_req_ctrl_pkg: shared types and constants for the bankgroup request controller
package bankgroup_req_ctrl_pkg;
  localparam int BUS_W = 33;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH} state_t;
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;
endpackage

// File: rtl/bankgroup_req_ctrl_if.sv
// bankgroup_req_ctrl_if: upstream request and response channels
interface bankgroup_req_ctrl_if;
  logic        req_valid, req_ready, req_we, req_pattern;
  logic [1:0]  req_fifo_sel;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  modport master (
    output req_valid, req_we, req_pattern, req_fifo_sel, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_pattern, req_fifo_sel, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/bankgroup_req_ctrl_rsp_queue.sv
// bankgroup_req_ctrl_rsp_queue: synchronous response FIFO; head reads as zero when empty
module bankgroup_req_ctrl_rsp_queue
  import bankgroup_req_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rsp_t                       push_rsp,
  input  logic                       pop,
  output rsp_t                       head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  rsp_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign empty = count == '0;
  assign head  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_rsp;
endmodule

// File: rtl/bankgroup_req_ctrl.sv
// bankgroup_req_ctrl: request sequencer for one bankgroup with credit-limited read response capture
module bankgroup_req_ctrl
  import bankgroup_req_ctrl_pkg::*;
#(
  parameter int RSP_DEPTH = 4,
  parameter int TO_CYC    = 15,
  parameter int FLUSH_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  bankgroup_req_ctrl_if.slave  bus,
  input  logic                 flush_req,
  output logic                 busy,
  output logic                 bg_en,
  output logic                 bg_we,
  output logic                 bg_re,
  output logic                 bg_pattern,
  output logic                 bg_flush,
  output logic [1:0]           bg_fifo_sel,
  output logic [9:0]           bg_addr,
  output logic [31:0]          bg_din,
  input  logic [BUS_W-1:0]     bg_dout_bus
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  state_t        state, state_nx;
  logic [CW-1:0] outstanding, q_count;
  logic [TW-1:0] to_cnt;
  logic [FW-1:0] fl_cnt;
  logic [1:0]    cur_fifo_sel;
  logic          cur_pattern, live, q_empty, flush_start;
  logic          same_mode, has_credit, fire, illegal, issue, in_valid, capture, timeout, push, pop;
  rsp_t          push_rsp, head;
  assign in_valid   = bg_dout_bus[BUS_W-1];
  assign same_mode  = bus.req_pattern == cur_pattern && bus.req_fifo_sel == cur_fifo_sel;
  assign has_credit = outstanding + q_count < CW'(RSP_DEPTH);
  assign fire       = bus.req_valid && bus.req_ready;
  assign illegal    = bus.req_pattern && bus.req_fifo_sel == 2'd3;
  assign issue      = fire && !bus.req_we && !illegal;
  assign capture    = in_valid && outstanding != '0;
  assign timeout    = !in_valid && outstanding != '0 && to_cnt == TW'(TO_CYC - 1);
  assign push       = capture || timeout || (fire && !bus.req_we && illegal);
  assign push_rsp   = capture ? {1'b0, bg_dout_bus[BUS_W-2:0]} : {1'b1, ERR_DATA};
  assign pop        = bus.rsp_ready && !q_empty;
  assign bus.rsp_valid = !q_empty;
  assign bus.rsp_data  = head.data;
  assign bus.rsp_err   = head.err;
  bankgroup_req_ctrl_rsp_queue #(.DEPTH(RSP_DEPTH)) u_rsp_queue (
    .clk(clk), .rst(rst), .push(push), .push_rsp(push_rsp), .pop(pop),
    .head(head), .count(q_count), .empty(q_empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_RUN;
    else      state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state != S_FLUSH && flush_req) ? S_FLUSH :
               (state == S_RUN && bus.req_valid && !same_mode && outstanding != '0) ? S_DRAIN :
               (state == S_DRAIN && outstanding == '0) ? S_RUN :
               (state == S_FLUSH && fl_cnt == FW'(FLUSH_CYC) && !flush_req) ? S_RUN : state;
  end
  always_comb begin
    bus.req_ready = live && state == S_RUN && !flush_req && (bus.req_we || has_credit) &&
                    (same_mode || outstanding == '0);
    busy          = state != S_RUN || outstanding != '0;
    flush_start   = state_nx == S_FLUSH && state != S_FLUSH;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live         <= 1'b0;
      outstanding  <= '0;
      to_cnt       <= '0;
      fl_cnt       <= '0;
      cur_pattern  <= 1'b0;
      cur_fifo_sel <= '0;
      bg_en        <= 1'b0;
      bg_we        <= 1'b0;
      bg_re        <= 1'b0;
      bg_flush     <= 1'b0;
      bg_pattern   <= 1'b0;
      bg_fifo_sel  <= '0;
      bg_addr      <= '0;
      bg_din       <= '0;
    end else begin
      live         <= 1'b1;
      outstanding  <= flush_start ? '0 : outstanding + CW'(issue) - CW'(capture || timeout);
      to_cnt       <= (flush_start || in_valid || outstanding == '0 || timeout) ? '0 : to_cnt + TW'(1);
      fl_cnt       <= state != S_FLUSH ? '0 : fl_cnt == FW'(FLUSH_CYC) ? fl_cnt : fl_cnt + FW'(1);
      cur_pattern  <= fire ? bus.req_pattern : cur_pattern;
      cur_fifo_sel <= fire ? bus.req_fifo_sel : cur_fifo_sel;
      bg_en        <= fire && !illegal;
      bg_we        <= fire && !illegal && bus.req_we;
      bg_re        <= issue;
      bg_flush     <= flush_start;
      if (fire && !illegal) begin
        bg_pattern  <= bus.req_pattern;
        bg_fifo_sel <= bus.req_fifo_sel;
        bg_addr     <= bus.req_addr;
        bg_din      <= bus.req_wdata;
      end
    end
  end
endmodule

// File: tb/tb_bankgroup_req_ctrl.sv
// tb_bankgroup_req_ctrl: directed checks of issue, credits, drain, timeout, flush and reset
module tb_bankgroup_req_ctrl;
  import bankgroup_req_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b0, flush_req = 1'b0, auto_rsp = 1'b0;
  logic busy, bg_en, bg_we, bg_re, bg_pattern, bg_flush;
  logic [1:0]  bg_fifo_sel;
  logic [9:0]  bg_addr;
  logic [31:0] bg_din;
  logic [BUS_W-1:0] bg_dout_bus, model_bus = '0, man_bus = '0;
  logic [31:0] mem [1024];
  int passes = 0, total = 0, acc;
  bankgroup_req_ctrl_if bus();
  bankgroup_req_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus), .flush_req(flush_req), .busy(busy),
    .bg_en(bg_en), .bg_we(bg_we), .bg_re(bg_re), .bg_pattern(bg_pattern), .bg_flush(bg_flush),
    .bg_fifo_sel(bg_fifo_sel), .bg_addr(bg_addr), .bg_din(bg_din), .bg_dout_bus(bg_dout_bus)
  );
  always #5 clk = ~clk;
  assign bg_dout_bus = auto_rsp ? model_bus : man_bus;
  // bankgroup stand-in: one-cycle read latency from bg_re
  always @(posedge clk) begin
    if (bg_we) mem[bg_addr] <= bg_din;
    model_bus <= bg_re ? {1'b1, mem[bg_addr]} : '0;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic send(input logic we, input logic pat, input logic [1:0] sel,
                      input logic [9:0] addr, input logic [31:0] data);
    bus.req_we = we; bus.req_pattern = pat; bus.req_fifo_sel = sel;
    bus.req_addr = addr; bus.req_wdata = data; bus.req_valid = 1'b1;
    #1;
    for (int i = 0; i < 40 && !bus.req_ready; i++) tick();
    chk("send_accept", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    #1;
  endtask
  task automatic pop_chk(input string tag, input logic [31:0] d, input logic e);
    chk({tag, "_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_data"}, bus.rsp_data, d);
    chk({tag, "_err"}, bus.rsp_err, e);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_pattern = 1'b0; bus.req_fifo_sel = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_bg_en", bg_en, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_state", dut.state, S_RUN);
    rst = 1'b1;
    tick();
    chk("run_req_ready", bus.req_ready, 1'b1);
    auto_rsp = 1'b1;
    send(1'b1, 1'b0, 2'd0, 10'h005, 32'hA5A5_A5A5);
    chk("wr_bg_we", bg_we, 1'b1);
    chk("wr_bg_re", bg_re, 1'b0);
    chk("wr_bg_en", bg_en, 1'b1);
    chk("wr_bg_addr", bg_addr, 10'h005);
    chk("wr_bg_din", bg_din, 32'hA5A5_A5A5);
    send(1'b0, 1'b0, 2'd0, 10'h005, 32'h0);
    chk("rd_bg_re", bg_re, 1'b1);
    chk("rd_bg_we", bg_we, 1'b0);
    chk("rd_busy", busy, 1'b1);
    tick();
    chk("rd_not_yet", bus.rsp_valid, 1'b0);
    tick();
    chk("rd_busy_done", busy, 1'b0);
    pop_chk("rd", 32'hA5A5_A5A5, 1'b0);
    chk("rd_empty", bus.rsp_valid, 1'b0);
    for (int i = 1; i <= 4; i++) send(1'b1, 1'b0, 2'd0, 10'(i), 32'h1111_0000 + i);
    acc = 0;
    bus.req_we = 1'b0; bus.req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.req_addr = 10'(acc + 1);
      #1;
      if (bus.req_ready) acc++;
      tick();
    end
    bus.req_valid = 1'b0;
    #1;
    chk("credit_accepts", 64'(acc), 64'd4);
    chk("credit_ready_low", bus.req_ready, 1'b0);
    for (int i = 1; i <= 4; i++) pop_chk("credit_order", 32'h1111_0000 + i, 1'b0);
    chk("credit_empty", bus.rsp_valid, 1'b0);
    auto_rsp = 1'b0;
    send(1'b0, 1'b1, 2'd0, 10'h0, 32'h0);
    send(1'b0, 1'b1, 2'd0, 10'h0, 32'h0);
    bus.req_fifo_sel = 2'd1; bus.req_valid = 1'b1;
    #1;
    chk("drain_ready0", bus.req_ready, 1'b0);
    tick();
    chk("drain_state", dut.state, S_DRAIN);
    man_bus = {1'b1, 32'hD000_0000};
    tick();
    chk("drain_ready1", bus.req_ready, 1'b0);
    man_bus = {1'b1, 32'hD000_0001};
    tick();
    man_bus = '0;
    chk("drain_ready2", bus.req_ready, 1'b0);
    tick();
    chk("drain_back_run", dut.state, S_RUN);
    chk("drain_ready3", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    chk("drain_issue_re", bg_re, 1'b1);
    chk("drain_issue_sel", bg_fifo_sel, 2'd1);
    chk("drain_issue_pat", bg_pattern, 1'b1);
    man_bus = {1'b1, 32'hD000_0002};
    tick();
    man_bus = '0;
    for (int i = 0; i < 3; i++) pop_chk("drain_order", 32'hD000_0000 + i, 1'b0);
    chk("drain_empty", bus.rsp_valid, 1'b0);
    send(1'b0, 1'b1, 2'd1, 10'h0, 32'h0);
    repeat (14) tick();
    chk("to_early", bus.rsp_valid, 1'b0);
    chk("to_busy", busy, 1'b1);
    tick();
    chk("to_busy_drop", busy, 1'b0);
    pop_chk("to", 32'hFFFF_FFFF, 1'b1);
    send(1'b0, 1'b1, 2'd3, 10'h0, 32'h0);
    chk("ill_bg_en", bg_en, 1'b0);
    chk("ill_bg_re", bg_re, 1'b0);
    chk("ill_rsp_err", bus.rsp_err, 1'b1);
    chk("ill_rsp_data", bus.rsp_data, 32'hFFFF_FFFF);
    send(1'b0, 1'b1, 2'd0, 10'h0, 32'h0);
    send(1'b0, 1'b1, 2'd0, 10'h0, 32'h0);
    chk("fl_outstanding2", dut.outstanding, 2);
    flush_req = 1'b1;
    #1;
    chk("fl_ready_blocked", bus.req_ready, 1'b0);
    tick();
    chk("fl_pulse", bg_flush, 1'b1);
    chk("fl_outstanding0", dut.outstanding, 0);
    flush_req = 1'b0;
    man_bus = {1'b1, 32'h0000_1234};
    tick();
    man_bus = '0;
    chk("fl_pulse_end", bg_flush, 1'b0);
    chk("fl_ready_c1", bus.req_ready, 1'b0);
    tick();
    chk("fl_ready_c2", bus.req_ready, 1'b0);
    chk("fl_busy", busy, 1'b1);
    tick();
    chk("fl_ready_back", bus.req_ready, 1'b1);
    chk("fl_busy_drop", busy, 1'b0);
    pop_chk("fl_kept", 32'hFFFF_FFFF, 1'b1);
    chk("fl_no_late", bus.rsp_valid, 1'b0);
    send(1'b0, 1'b1, 2'd0, 10'h0, 32'h0);
    chk("mr_bg_re", bg_re, 1'b1);
    man_bus = {1'b1, 32'h0000_BEEF};
    rst = 1'b0;
    #1;
    chk("mr_bg_re0", bg_re, 1'b0);
    chk("mr_bg_en0", bg_en, 1'b0);
    chk("mr_busy0", busy, 1'b0);
    chk("mr_ready0", bus.req_ready, 1'b0);
    tick();
    rst = 1'b1;
    man_bus = '0;
    tick(); tick();
    chk("mr_no_rsp", bus.rsp_valid, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_bg_addr", bg_addr, 10'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
